// File: rtl/regfile_bank_if.sv
// rtl/regfile_bank_if.sv - write/read/scoreboard signal bundle for regfile_bank
interface regfile_bank_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic              we;
    logic [AW-1:0]     waddr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    logic [AW-1:0]     raddr1;
    logic [XLEN-1:0]   rdata1;
    logic [AW-1:0]     raddr2;
    logic [XLEN-1:0]   rdata2;
    logic              busy_set;
    logic [AW-1:0]     busy_addr;
    logic              flush;
    logic              rbusy1;
    logic              rbusy2;

    modport master (
        output we, waddr, wdata, wstrb, raddr1, raddr2, busy_set, busy_addr, flush,
        input  rdata1, rdata2, rbusy1, rbusy2
    );

    modport slave (
        input  we, waddr, wdata, wstrb, raddr1, raddr2, busy_set, busy_addr, flush,
        output rdata1, rdata2, rbusy1, rbusy2
    );
endinterface

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - NREG x XLEN register file, 1W/2R, byte strobes, x0, bypass, pending-write scoreboard
module regfile_bank #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input logic            clk,
    input logic            rst_n,
    regfile_bank_if.slave  bus
);
    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            wr_en;

    assign wr_en = bus.we && (bus.waddr != '0);

    // Later assignments override earlier ones: flush beats set beats write-clear.
    always_comb begin
        busy_next = busy;
        if (wr_en)
            busy_next[bus.waddr] = 1'b0;
        if (bus.busy_set && (bus.busy_addr != '0))
            busy_next[bus.busy_addr] = 1'b1;
        if (bus.flush)
            busy_next = '0;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            busy <= busy_next;
            if (wr_en) begin
                for (int b = 0; b < NB; b++)
                    if (bus.wstrb[b])
                        regs[bus.waddr][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    logic [AW-1:0]   ra   [2];
    logic [XLEN-1:0] rd   [2];
    logic            rb   [2];
    logic            hit  [2];

    assign ra[0] = bus.raddr1;
    assign ra[1] = bus.raddr2;

    // Forwarding is gated by rst_n so outputs read zero throughout reset.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit[p] = (BYPASS != 0) && rst_n && wr_en && (bus.waddr == ra[p]);
            rd[p]  = regs[ra[p]];
            rb[p]  = busy[ra[p]];
            if (hit[p]) begin
                for (int b = 0; b < NB; b++)
                    if (bus.wstrb[b])
                        rd[p][8*b +: 8] = bus.wdata[8*b +: 8];
                rb[p] = 1'b0;
            end
            if (ra[p] == '0) begin
                rd[p] = '0;
                rb[p] = 1'b0;
            end
        end
    end

    assign bus.rdata1 = rd[0];
    assign bus.rdata2 = rd[1];
    assign bus.rbusy1 = rb[0];
    assign bus.rbusy2 = rb[1];
endmodule

// File: tb/tb_regfile_bank.sv
// tb/tb_regfile_bank.sv - scoreboard bench for regfile_bank, BYPASS=1 and BYPASS=0 side by side
module tb_regfile_bank;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_bank_if #(.XLEN(XLEN), .AW(AW)) bus_a ();
    regfile_bank_if #(.XLEN(XLEN), .AW(AW)) bus_b ();

    regfile_bank #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    regfile_bank #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        logic [31:0] d1a, d2a, d1b, d2b;
        logic        b1a, b2a, b1b, b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] m_regs [NREG];
    bit          m_busy [NREG];

    bit          cur_rstn;
    bit          cur_we;
    logic [4:0]  cur_wa;
    logic [31:0] cur_wd;
    logic [3:0]  cur_ws;

    function automatic logic [31:0] m_read(bit bp, logic [4:0] ra);
        logic [31:0] v;
        if (!cur_rstn || ra == 5'd0)
            return 32'd0;
        v = m_regs[ra];
        if (bp && cur_we && cur_wa == ra)
            for (int i = 0; i < 4; i++)
                if (cur_ws[i]) v[8*i +: 8] = cur_wd[8*i +: 8];
        return v;
    endfunction

    function automatic bit m_busy_rd(bit bp, logic [4:0] ra);
        if (!cur_rstn || ra == 5'd0)
            return 1'b0;
        if (bp && cur_we && cur_wa == ra)
            return 1'b0;
        return m_busy[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rdata1_byp",   bus_a.rdata1,         e.d1a);
            chk("rdata2_byp",   bus_a.rdata2,         e.d2a);
            chk("rbusy1_byp",   {31'd0, bus_a.rbusy1}, {31'd0, e.b1a});
            chk("rbusy2_byp",   {31'd0, bus_a.rbusy2}, {31'd0, e.b2a});
            chk("rdata1_nobyp", bus_b.rdata1,         e.d1b);
            chk("rdata2_nobyp", bus_b.rdata2,         e.d2b);
            chk("rbusy1_nobyp", {31'd0, bus_b.rbusy1}, {31'd0, e.b1b});
            chk("rbusy2_nobyp", {31'd0, bus_b.rbusy2}, {31'd0, e.b2b});
        end
    end

    // rm: 0 = normal cycle, 1 = reset held across the next edge, 2 = reset pulse between edges
    task automatic step(input int rm, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [4:0] r1, input logic [4:0] r2,
                        input bit bs, input logic [4:0] ba, input bit fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = (rm == 0);
        bus_a.we = we;  bus_a.waddr = wa; bus_a.wdata = wd; bus_a.wstrb = ws;
        bus_a.raddr1 = r1; bus_a.raddr2 = r2;
        bus_a.busy_set = bs; bus_a.busy_addr = ba; bus_a.flush = fl;
        bus_b.we = we;  bus_b.waddr = wa; bus_b.wdata = wd; bus_b.wstrb = ws;
        bus_b.raddr1 = r1; bus_b.raddr2 = r2;
        bus_b.busy_set = bs; bus_b.busy_addr = ba; bus_b.flush = fl;
        cur_rstn = (rm == 0);
        cur_we = we; cur_wa = wa; cur_wd = wd; cur_ws = ws;
        if (rm != 0)
            model_reset();
        e.d1a = m_read(1'b1, r1);    e.d2a = m_read(1'b1, r2);
        e.b1a = m_busy_rd(1'b1, r1); e.b2a = m_busy_rd(1'b1, r2);
        e.d1b = m_read(1'b0, r1);    e.d2b = m_read(1'b0, r2);
        e.b1b = m_busy_rd(1'b0, r1); e.b2b = m_busy_rd(1'b0, r2);
        exp_q.push_back(e);
        if (rm != 1) begin
            if (we && wa != 5'd0) begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) m_regs[wa][8*i +: 8] = wd[8*i +: 8];
                m_busy[wa] = 1'b0;
            end
            if (bs && ba != 5'd0)
                m_busy[ba] = 1'b1;
            if (fl)
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end
        if (rm == 2) begin
            @(negedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(0, 0, 5'd0, 32'd0, 4'h0, r1, r2, 0, 5'd0, 0);
    endtask

    initial begin
        bus_a.we = 0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.wstrb = '0;
        bus_a.raddr1 = '0; bus_a.raddr2 = '0; bus_a.busy_set = 0; bus_a.busy_addr = '0; bus_a.flush = 0;
        bus_b.we = 0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.wstrb = '0;
        bus_b.raddr1 = '0; bus_b.raddr2 = '0; bus_b.busy_set = 0; bus_b.busy_addr = '0; bus_b.flush = 0;
        model_reset();

        for (int i = 0; i < 3; i++)
            step(1, 1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd5, 1, 5'd5, 0);
        step(0, 1, 5'd5, 32'h12345678, 4'hF, 5'd5, 5'd0, 0, 5'd0, 0);
        idle(5'd5, 5'd5);

        step(0, 1, 5'd7, 32'h11223344, 4'hF, 5'd0, 5'd7, 0, 5'd0, 0);
        step(0, 1, 5'd7, 32'hAABBCCDD, 4'b0101, 5'd0, 5'd7, 0, 5'd0, 0);
        idle(5'd0, 5'd7);

        step(0, 1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 1, 5'd0, 0);
        idle(5'd0, 5'd0);

        step(0, 1, 5'd9, 32'hCAFEF00D, 4'hF, 5'd9, 5'd9, 0, 5'd0, 0);
        idle(5'd9, 5'd9);

        step(0, 0, 5'd0, 32'd0, 4'h0, 5'd3, 5'd0, 1, 5'd3, 0);
        idle(5'd3, 5'd3);
        step(0, 1, 5'd3, 32'h00000033, 4'hF, 5'd3, 5'd3, 0, 5'd0, 0);
        idle(5'd3, 5'd3);

        step(0, 1, 5'd4, 32'h44444444, 4'hF, 5'd4, 5'd4, 1, 5'd4, 0);
        idle(5'd4, 5'd4);
        step(0, 0, 5'd0, 32'd0, 4'h0, 5'd6, 5'd0, 1, 5'd6, 0);
        step(0, 1, 5'd6, 32'h66666666, 4'hF, 5'd4, 5'd6, 1, 5'd4, 0);
        idle(5'd4, 5'd6);

        step(0, 0, 5'd0, 32'd0, 4'h0, 5'd5, 5'd0, 1, 5'd5, 0);
        step(0, 0, 5'd0, 32'd0, 4'h0, 5'd8, 5'd5, 1, 5'd8, 1);
        idle(5'd8, 5'd5);
        idle(5'd4, 5'd6);

        step(0, 1, 5'd10, 32'h00000055, 4'hF, 5'd0, 5'd0, 0, 5'd0, 0);
        step(0, 0, 5'd0, 32'd0, 4'h0, 5'd10, 5'd0, 1, 5'd10, 0);
        idle(5'd10, 5'd10);
        step(2, 0, 5'd0, 32'd0, 4'h0, 5'd10, 5'd10, 0, 5'd0, 0);
        idle(5'd10, 5'd10);

        for (int n = 0; n < 400; n++) begin
            int rm;
            rm = ($urandom_range(0, 59) == 0) ? 2 : 0;
            step(rm, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 15) == 0));
        end
        idle(5'd0, 5'd0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++)
            @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised integer register file for the RockWave core. Generalises the single write-enabled data register into NREG registers with one write port and two read ports.
- Adds byte-strobe writes, a hardwired-zero x0, an optional write-to-read bypass, and a per-register pending-write scoreboard.
- Sits between decode (reads, busy checks) and writeback (writes, busy clears).

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8.
- NREG, 32, number of architectural registers; must be a power of 2 and at least 2.
- AW, 5, address width; must equal log2(NREG).
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- we  input  1  write enable
- waddr  input  AW  write register index
- wdata  input  XLEN  write data
- wstrb  input  XLEN/8  byte write strobes; bit i covers wdata[8i+7:8i]
- raddr1  input  AW  read port 1 index
- rdata1  output  XLEN  read port 1 data
- raddr2  input  AW  read port 2 index
- rdata2  output  XLEN  read port 2 data
- busy_set  input  1  mark busy_addr as having a pending write
- busy_addr  input  AW  register to mark pending
- flush  input  1  clear all pending marks
- rbusy1  output  1  raddr1 has a pending write
- rbusy2  output  1  raddr2 has a pending write

Behaviour:
- Clocking/reset: single clock clk, rising edge. Reset rst_n is asynchronous, active-low.
- During reset: all NREG data registers = 0 and all busy bits = 0. Consequently rdata1/rdata2 = 0 and rbusy1/rbusy2 = 0 while reset is asserted.
- Write: at a clk rising edge with we=1 and waddr!=0, byte i of reg[waddr] takes wdata byte i for each wstrb[i]=1; other bytes hold.
  - we=1 with wstrb=0 changes no data but still clears busy (see below).
  - we=0: no register changes.
- x0: reg[0] always reads 0, is never written, and is never busy. Writes and busy_set to index 0 are ignored.
- Read: combinational, zero-cycle latency. rdataN = reg[raddrN], except as noted below.
- Bypass (BYPASS=1): if we=1, waddr==raddrN and waddr!=0, rdataN = merged value. The merged value takes each byte from wdata where wstrb=1, otherwise from reg[raddrN].
- BYPASS=0: rdataN shows the new value only from the cycle after the write edge.
- Both read ports may address the same register; each returns identical data.
- Scoreboard: one busy bit per register, updated at the clk edge. Priority, highest first:
  1. flush=1: all busy bits cleared; busy_set that cycle is ignored.
  2. busy_set=1 and busy_addr!=0: busy[busy_addr] set to 1. If we=1 with waddr==busy_addr in the same cycle, set wins (a new producer has issued).
  3. we=1 and waddr!=0: busy[waddr] cleared.
  - A set and a clear to different addresses in the same cycle both take effect.
- rbusyN = busy[raddrN], except in these cases:
  - Forced to 0 when raddrN==0.
  - With BYPASS=1, forced to 0 when we=1 and waddr==raddrN in the current cycle, because the value is being forwarded.
- flush has no effect on register data.
- Reset mid-operation: asynchronous clear takes effect immediately, independent of clk. A write coinciding with reset assertion is lost. The first write is accepted at the first rising edge after rst_n deasserts.
- No arithmetic or wrap-around behaviour. Out-of-range indices cannot occur because NREG = 2^AW.

Test Plan:
- Reset: hold rst_n=0 while driving we=1, waddr=5, wdata=0xDEADBEEF with clk toggling. Required: rdata1 for raddr1=5 stays 0x00000000 and rbusy1=0. After release, write 0x12345678 to x5 with wstrb=0xF; the next cycle rdata1 = 0x12345678.
- Byte strobes: x7 = 0x11223344; write wdata=0xAABBCCDD with wstrb=0b0101. Required: next cycle rdata2 = 0x11BB33DD.
- x0 and bypass: write 0xFFFFFFFF to x0 → rdata1 with raddr1=0 stays 0 in every cycle. With BYPASS=1, x9=0, write 0xCAFEF00D to x9 with raddr1=raddr2=9 → both ports show 0xCAFEF00D in the same cycle. Repeat with BYPASS=0 → 0 in that cycle, 0xCAFEF00D the following cycle.
- Scoreboard basic: busy_set on x3 → next cycle rbusy1=1 for raddr1=3. Write x3 → rbusy1=0 in the write cycle (BYPASS=1) and after the edge.
- Scoreboard collisions:
  - busy_set x4 together with write x4 → busy[4]=1 afterward.
  - busy_set x4 together with write x6 (x6 busy) → busy[4]=1, busy[6]=0.
  - flush together with busy_set x8 → all busy bits 0.
- Async reset mid-stream: with x10 busy and holding 0x55, pulse rst_n low between clock edges. Required: rbusy and rdata for x10 go to 0 immediately, before the next clk edge.
